// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard / forwarding unit.
// Holds the architectural register geometry, the forwarding-select encoding
// and small helpers that the top and the scoreboard both use.
package hazard_forward_unit_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int SEL_RF = 0;

    localparam int          STALL_CNT_W   = 32;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    typedef logic [REG_ADDR_W-1:0]    reg_addr_t;
    typedef logic [NUM_ARCH_REGS-1:0] reg_mask_t;

    // One-hot mask selecting a single architectural register.
    function automatic reg_mask_t addr_bit(input reg_addr_t addr);
        reg_mask_t mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] val);
        return (val == STALL_CNT_MAX) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_scoreboard.sv
// Multicycle-op scoreboard.
// Keeps one pending bit per architectural register for mul/div results that
// are still in flight, and flags a WAW hazard when a new issue targets a
// register that is still pending.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              clears every pending bit at the next edge
//   issue_valid/rd     multicycle op presented for issue
//   issue_accept       issue is actually taken this cycle (no stall)
//   done_valid/rd      multicycle result completing this cycle
//   pending            current pending bits (bit 0 always 0)
//   waw_hazard         issue targets a still-pending register
module hazard_scoreboard
    import hazard_forward_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      issue_accept,
    input  logic      done_valid,
    input  reg_addr_t done_rd,
    output reg_mask_t pending,
    output logic      waw_hazard
);

    reg_mask_t pending_q;
    reg_mask_t pending_d;

    // A completion of the same rd in this cycle frees the register, so no WAW.
    always_comb begin
        waw_hazard = issue_valid & pending_q[issue_rd] &
                     ~(done_valid & (done_rd == issue_rd));
    end

    // Next pending state: clear on completion first, then set on issue, so a
    // same-rd issue wins; flush discards everything.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            pending_d = pending_q & ~(done_valid ? addr_bit(done_rd) : reg_mask_t'(0));
            pending_d = pending_d | ((issue_valid & issue_accept) ? addr_bit(issue_rd)
                                                                  : reg_mask_t'(0));
        end
        // x0 can never be the target of an outstanding write.
        pending_d[0] = 1'b0;
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// For each read port, picks the youngest pipeline stage writing the source
// register (zero latency) and raises a stall for load-use, scoreboard
// (multicycle result outstanding) and WAW hazards.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rs_addr, rs_used      packed source addresses / port-really-reads flags
//   stage_rd/we/rdy       per-stage destination, write enable, result ready
//   mc_issue_*, mc_done_* multicycle op issue and completion
//   flush                 pipeline flush
//   fwd_sel               per-port select: 0 = register file, k = stage k
//   stall                 freeze decode/issue this cycle
//   pending               scoreboard bit per architectural register
//   stall_cycles          saturating count of stalled cycles
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_STAGES   = 3,
    parameter int SEL_W        = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rs_addr,
    input  logic [NUM_RD_PORTS-1:0]            rs_used,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0]   stage_rd,
    input  logic [NUM_STAGES-1:0]              stage_we,
    input  logic [NUM_STAGES-1:0]              stage_rdy,
    input  logic                               mc_issue_valid,
    input  logic [REG_ADDR_W-1:0]              mc_issue_rd,
    input  logic                               mc_done_valid,
    input  logic [REG_ADDR_W-1:0]              mc_done_rd,
    input  logic                               flush,
    output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel,
    output logic                               stall,
    output logic [NUM_ARCH_REGS-1:0]           pending,
    output logic [STALL_CNT_W-1:0]             stall_cycles
);

    logic [NUM_RD_PORTS-1:0] load_use_s;
    logic [NUM_RD_PORTS-1:0] sb_haz_s;
    logic                    waw_s;
    reg_mask_t               pending_s;
    logic [STALL_CNT_W-1:0]  stall_cycles_q;
    logic [STALL_CNT_W-1:0]  stall_cycles_d;

    // Per-port youngest-match selection and load-use / scoreboard hazards.
    always_comb begin
        reg_addr_t        addr_v;
        logic [SEL_W-1:0] sel_v;
        logic             hit_v;
        logic             hit_rdy_v;
        fwd_sel    = '0;
        load_use_s = '0;
        sb_haz_s   = '0;
        addr_v     = '0;
        sel_v      = '0;
        hit_v      = 1'b0;
        hit_rdy_v  = 1'b1;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            addr_v    = rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
            sel_v     = SEL_W'(SEL_RF);
            hit_rdy_v = 1'b1;
            // Scan oldest to youngest so the youngest match overwrites.
            for (int k = NUM_STAGES; k >= 1; k--) begin
                hit_v = stage_we[k-1] &&
                        (stage_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == addr_v) &&
                        (addr_v != '0);
                sel_v     = hit_v ? SEL_W'(k) : sel_v;
                hit_rdy_v = hit_v ? stage_rdy[k-1] : hit_rdy_v;
            end
            fwd_sel[p*SEL_W +: SEL_W] = sel_v;
            // Not-ready youngest match must stall; an older stage is never used instead.
            load_use_s[p] = rs_used[p] & ~hit_rdy_v;
            // A result arriving this cycle satisfies a pending source.
            sb_haz_s[p]   = rs_used[p] & pending_s[addr_v] &
                            ~(mc_done_valid & (mc_done_rd == addr_v));
        end
    end

    // Stall combines every hazard source; a flush cancels it.
    always_comb begin
        stall = ~flush & ((|load_use_s) | (|sb_haz_s) | waw_s);
    end

    hazard_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (mc_issue_valid),
        .issue_rd     (mc_issue_rd),
        .issue_accept (~stall),
        .done_valid   (mc_done_valid),
        .done_rd      (mc_done_rd),
        .pending      (pending_s),
        .waw_hazard   (waw_s)
    );

    // Next value of the stalled-cycle counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stalled-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending      = pending_s;
    assign stall_cycles = stall_cycles_q;

endmodule
